accu_sequencer: RTL
===================

Name: accu_sequencer

Overview:
- Control unit for the 4-bit accumulator datapath. It drives the datapath's control inputs: enBuff1, enBuff2, enAccu, F and the busInput operand. It consumes the datapath's C/Z outputs.
- It fetches 8-bit instructions from an external combinational program ROM, decodes them, executes them one per instruction cycle, and resolves conditional jumps on latched flags.

Parameters:
- ADDR_W, 8, program counter / ROM address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  start request; sampled only in IDLE.
- prog_data  input  8  ROM word at address pc; combinational, valid in the same cycle.
- pc  output  ADDR_W  program counter / ROM address.
- operand  output  4  immediate driven onto datapath busInput.
- F  output  3  ALU function select.
- enBuff1  output  1  input buffer enable.
- enBuff2  output  1  output buffer enable.
- enAccu  output  1  accumulator load enable.
- C_in  input  1  datapath carry.
- Z_in  input  1  datapath zero.
- c_flag  output  1  latched carry flag.
- z_flag  output  1  latched zero flag.
- out_strobe  output  1  one-cycle pulse; busOutput is valid.
- halted  output  1  high in HALT state.

Behaviour:
- Instruction word: opcode = [7:4], imm = [3:0].
- ALU function codes driven on F: PASS_A=000, SUB=001, PASS_B=010, ADD=011, NAND=100.
- Opcodes:
  - 0 NOP.
  - 1 LIT: acc<=imm.
  - 2 ADD: acc<=acc+imm.
  - 3 SUB: acc<=acc-imm.
  - 4 NAND: acc<=acc nand imm.
  - 5 CMP: flags only.
  - 6 OUT.
  - 7 JC, 8 JZ, 9 JNC, A JNZ, B JMP: two-byte instructions; the second byte is the absolute target.
  - F HALT.
  - C, D, E execute as NOP.
- States: IDLE, FETCH, EXEC, JADDR, HALT.
- Reset (async, reset=0):
  - state=IDLE, pc=0, IR=0, c_flag=z_flag=0.
  - operand=0, F=000; enBuff1, enBuff2, enAccu, out_strobe, halted all 0.
  - Reset mid-instruction aborts it; no enable may glitch high during reset.
- IDLE: all enables 0. run=1 -> FETCH. run is ignored in every other state.
- FETCH:
  - IR<=prog_data; pc<=pc+1; all enables 0.
  - Next state is JADDR for opcodes 7-B, HALT for F, otherwise EXEC.
- EXEC (exactly one cycle): outputs are combinational from IR.
  - LIT/ADD/SUB/NAND: enBuff1=1, operand=imm, F per op (LIT=PASS_B), enAccu=1; the accumulator loads at the end of the cycle.
  - CMP: as SUB, but enAccu=0.
  - Opcodes 2-5 latch c_flag<=C_in and z_flag<=Z_in at the end of EXEC. LIT, NOP and OUT leave the flags unchanged.
  - OUT: F=PASS_A, enBuff2=1, out_strobe=1, enBuff1=0, enAccu=0.
  - NOP: all enables 0.
  - Next state is FETCH.
- JADDR (one cycle): prog_data holds the target.
  - Taken if: JMP; JC and c_flag; JZ and z_flag; JNC and !c_flag; JNZ and !z_flag.
  - Taken: pc<=prog_data[ADDR_W-1:0], zero-extended if ADDR_W>8. Not taken: pc<=pc+1.
  - Next state is FETCH. Enables are 0.
- Latency: ALU/OUT/NOP instructions take 2 cycles; jumps take 2 cycles whether or not taken; HALT takes 1 cycle to enter.
- HALT: halted=1, enables 0, pc frozen. Only reset exits HALT.
- pc wraps modulo 2^ADDR_W; fetch at the last address proceeds to 0.
- A jump opcode at the last address fetches its target byte from address 0.
- Flags tested by a jump are those latched by the most recent opcode 2-5. There are no flag-forwarding hazards because flags are latched before the next FETCH.
- Outside EXEC, operand=0 and F=000.

Decomposition:
- Shared package accu_pkg holds:
  - opcode constants: OP_NOP, OP_LIT, OP_ADD, OP_SUB, OP_NAND, OP_CMP, OP_OUT, OP_JC, OP_JZ, OP_JNC, OP_JNZ, OP_JMP, OP_HALT;
  - ALU function codes: F_PASS_A, F_SUB, F_PASS_B, F_ADD, F_NAND;
  - the state enum.
- One natural sub-module, accu_decoder: purely combinational, IR + state -> enBuff1, enBuff2, enAccu, F, operand, out_strobe, flag_we, is_jump.
- PC, IR, flags and the FSM stay in the top.

Test Plan:
- Reset, then run=1 with ROM {0x15, 0x23, 0x60, 0xF0} -> pc sequences 0,1,1,2,2,3,3,4; after ADD the accumulator is 8; out_strobe pulses once with busOutput=8; halted=1 and pc stays 4.
- ROM {0x1F, 0x21, 0x80, 0x10, 0xF0} -> ADD 15+1 gives c_flag=1, z_flag=1; JZ is taken to address 0x10; pc=0x10 two cycles after the JZ fetch.
- ROM {0x13, 0x53, 0xA0, 0x08, 0xF0} -> CMP sets z_flag=1 with enAccu=0 during CMP EXEC; JNZ is not taken; pc=4 after JADDR; halts at 4.
- ADDR_W=4, pc=15 holding 0x6x -> OUT executes; next fetch is at pc=0.
- Assert reset=0 asynchronously during EXEC of ADD -> enAccu drops immediately; state=IDLE; pc=0; flags 0; no further activity until run=1.
- run pulsed while in EXEC or HALT -> no effect; halted stays 1 until reset.

Source files
------------

// File: rtl/accu_pkg.sv
// Shared opcode, ALU function and FSM definitions for the accumulator sequencer.
package accu_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned F_W     = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LIT  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_NAND = 4'h4;
  localparam logic [OP_W-1:0] OP_CMP  = 4'h5;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h6;
  localparam logic [OP_W-1:0] OP_JC   = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ   = 4'h8;
  localparam logic [OP_W-1:0] OP_JNC  = 4'h9;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [F_W-1:0] F_PASS_A = 3'b000;
  localparam logic [F_W-1:0] F_SUB    = 3'b001;
  localparam logic [F_W-1:0] F_PASS_B = 3'b010;
  localparam logic [F_W-1:0] F_ADD    = 3'b011;
  localparam logic [F_W-1:0] F_NAND   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_JADDR,
    S_HALT
  } state_t;

  function automatic logic is_jump_op(input logic [OP_W-1:0] op);
    return (op >= OP_JC) && (op <= OP_JMP);
  endfunction

  // Branch condition against the flags latched by the last ALU/compare op.
  function automatic logic jump_taken(input logic [OP_W-1:0] op, input logic c, input logic z);
    case (op)
      OP_JC:   return c;
      OP_JZ:   return z;
      OP_JNC:  return !c;
      OP_JNZ:  return !z;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/accu_sequencer_if.sv
// Program ROM and datapath control bundle between the sequencer and its environment.
interface accu_sequencer_if
  import accu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic               run;
  logic [INSTR_W-1:0] prog_data;
  logic [ADDR_W-1:0]  pc;
  logic [3:0]         operand;
  logic [F_W-1:0]     F;
  logic               enBuff1;
  logic               enBuff2;
  logic               enAccu;
  logic               C_in;
  logic               Z_in;
  logic               c_flag;
  logic               z_flag;
  logic               out_strobe;
  logic               halted;

  modport master (
    input  run, prog_data, C_in, Z_in,
    output pc, operand, F, enBuff1, enBuff2, enAccu, c_flag, z_flag, out_strobe, halted
  );

  modport slave (
    output run, prog_data, C_in, Z_in,
    input  pc, operand, F, enBuff1, enBuff2, enAccu, c_flag, z_flag, out_strobe, halted
  );
endinterface

// File: rtl/accu_decoder.sv
// Combinational instruction decode: IR + state to datapath controls.
module accu_decoder
  import accu_pkg::*;
(
  input  state_t             state,
  input  logic [INSTR_W-1:0] ir,
  output logic               enBuff1,
  output logic               enBuff2,
  output logic               enAccu,
  output logic [F_W-1:0]     F,
  output logic [3:0]         operand,
  output logic               out_strobe,
  output logic               flag_we,
  output logic               is_jump
);

  logic [OP_W-1:0] op;
  assign op = ir[7:4];

  // Datapath is only driven during EXEC; everything else idles at zero.
  always_comb begin
    enBuff1    = 1'b0;
    enBuff2    = 1'b0;
    enAccu     = 1'b0;
    F          = F_PASS_A;
    operand    = 4'h0;
    out_strobe = 1'b0;
    flag_we    = 1'b0;
    is_jump    = is_jump_op(op);
    if (state == S_EXEC) begin
      case (op)
        OP_LIT: begin
          enBuff1 = 1'b1;
          enAccu  = 1'b1;
          F       = F_PASS_B;
          operand = ir[3:0];
        end
        OP_ADD, OP_SUB, OP_NAND: begin
          enBuff1 = 1'b1;
          enAccu  = 1'b1;
          operand = ir[3:0];
          flag_we = 1'b1;
          F       = (op == OP_ADD) ? F_ADD : ((op == OP_SUB) ? F_SUB : F_NAND);
        end
        OP_CMP: begin
          enBuff1 = 1'b1;
          F       = F_SUB;
          operand = ir[3:0];
          flag_we = 1'b1;
        end
        OP_OUT: begin
          F          = F_PASS_A;
          enBuff2    = 1'b1;
          out_strobe = 1'b1;
        end
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/accu_sequencer.sv
// Fetch/execute control unit for the 4-bit accumulator datapath.
module accu_sequencer
  import accu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input logic               clk,
  input logic               reset,
  accu_sequencer_if.master  bus
);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic [INSTR_W-1:0]  ir, ir_next;
  logic                c_flag, c_next;
  logic                z_flag, z_next;
  logic                flag_we;
  logic                is_jump;
  logic                taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      ir     <= ir_next;
      c_flag <= c_next;
      z_flag <= z_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    c_next     = c_flag;
    z_next     = z_flag;
    taken      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.run) state_next = S_FETCH;
      end
      S_FETCH: begin
        ir_next = bus.prog_data;
        pc_next = pc + ADDR_W'(1);
        if (is_jump_op(bus.prog_data[7:4]))        state_next = S_JADDR;
        else if (bus.prog_data[7:4] == OP_HALT)    state_next = S_HALT;
        else                                       state_next = S_EXEC;
      end
      S_EXEC: begin
        if (flag_we) begin
          c_next = bus.C_in;
          z_next = bus.Z_in;
        end
        state_next = S_FETCH;
      end
      // Second byte of a jump is on prog_data; pc already points at it.
      S_JADDR: begin
        taken      = is_jump && jump_taken(ir[7:4], c_flag, z_flag);
        pc_next    = taken ? ADDR_W'(bus.prog_data) : pc + ADDR_W'(1);
        state_next = S_FETCH;
      end
      S_HALT:  ;
      default: state_next = S_IDLE;
    endcase
  end

  accu_decoder u_decoder (
    .state      (state),
    .ir         (ir),
    .enBuff1    (bus.enBuff1),
    .enBuff2    (bus.enBuff2),
    .enAccu     (bus.enAccu),
    .F          (bus.F),
    .operand    (bus.operand),
    .out_strobe (bus.out_strobe),
    .flag_we    (flag_we),
    .is_jump    (is_jump)
  );

  assign bus.pc     = pc;
  assign bus.c_flag = c_flag;
  assign bus.z_flag = z_flag;
  assign bus.halted = (state == S_HALT);

endmodule
